pb_debounce: RTL

//  Conditions a raw, bouncy, active-low push-button for the core logic.
//  - Sibling of the reset conditioner on the same button/pin class.
//  - The reset conditioner only forces asserts/releases reset; this block emits clean

---
 rtl/pb_debounce.sv | 98 +++++++++
 1 files changed

// File: rtl/pb_debounce.sv
// pb_debounce: synchronizes and debounces an active-low push-button into a level
// plus registered press / release / long-press pulses.
module pb_debounce #(
  parameter int DB_W     = 17,
  parameter int DB_CNT   = 100000,
  parameter int LONG_W   = 26,
  parameter int LONG_CNT = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PB,
  output logic pressed,
  output logic press,
  output logic released,
  output logic long_press
);
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CNT - 1);
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CNT);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);
  state_t            state_q, state_d;
  logic              ff1_q, ff2_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [LONG_W-1:0] hold_cnt_q, hold_cnt_d;
  // Pending events {press, release, long}; staged one cycle before the output pulses.
  logic [2:0]        evt_q, evt_d;
  logic              pressed_q, pressed_d;
  logic              press_q, released_q, long_press_q;
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    evt_d      = 3'b000;
    case (state_q)
      IDLE: begin
        db_cnt_d = ff2_q ? '0 : DB_W'(1);
        state_d  = ff2_q ? IDLE : PRESS_DB;
      end
      PRESS_DB:
        if (ff2_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = HELD;
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          evt_d[2]   = 1'b1;
        end else db_cnt_d = db_cnt_q + DB_W'(1);
      HELD:
        if (ff2_q) begin
          state_d  = REL_DB;
          db_cnt_d = DB_W'(1);
        end else if (hold_cnt_q != LONG_MAX) begin
          hold_cnt_d = hold_cnt_q + LONG_W'(1);
          evt_d[0]   = hold_cnt_q == LONG_LAST;
        end
      REL_DB:
        if (!ff2_q) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
          evt_d[1] = 1'b1;
        end else db_cnt_d = db_cnt_q + DB_W'(1);
      default: state_d = IDLE;
    endcase
    pressed_d = evt_q[2] | (pressed_q & ~evt_q[1]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ff1_q        <= 1'b1;
      ff2_q        <= 1'b1;
      state_q      <= IDLE;
      db_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      evt_q        <= 3'b000;
      pressed_q    <= 1'b0;
      press_q      <= 1'b0;
      released_q   <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      ff1_q        <= PB;
      ff2_q        <= ff1_q;
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      evt_q        <= evt_d;
      pressed_q    <= pressed_d;
      press_q      <= evt_q[2];
      released_q   <= evt_q[1];
      long_press_q <= evt_q[0];
    end
  assign pressed    = pressed_q;
  assign press      = press_q;
  assign released   = released_q;
  assign long_press = long_press_q;
endmodule
